// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high time of an async input in whole microseconds
module pulse_width_meter #(
   parameter int CLOCK_SPEED_MHZ = 12,
   parameter int MAX_US          = 65535,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           enable,
   input  logic                           sig_in,
   output logic [$clog2(MAX_US+1)-1:0]    width_us,
   output logic                           valid,
   output logic                           overflow,
   output logic                           busy
);

   localparam int UW = $clog2(MAX_US + 1);
   localparam int PW = $clog2(CLOCK_SPEED_MHZ) + 1;
   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_SPEED_MHZ - 1);
   localparam logic [UW-1:0] US_MAX     = UW'(MAX_US);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOW,
      S_ARM,
      S_MEASURE,
      S_OVER,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [SS-1:0]   sync_q;
   logic [SS-1:0]   prime_q;
   logic            sp_q;
   logic [PW-1:0]   presc_q, presc_d;
   logic [UW-1:0]   us_q, us_d;
   logic            over_q, over_d;
   logic [UW-1:0]   width_q;
   logic            ovf_q;
   logic            valid_q;

   logic            s, rise, fall, primed;
   logic [PW-1:0]   base_p, inc_p;
   logic [UW-1:0]   base_u, inc_u;
   logic            wrap, hit;

   assign s      = sync_q[SS-1];
   assign rise   = s & ~sp_q;
   assign fall   = ~s & sp_q;
   // The chain is cleared by reset, so its output is not trusted until it has
   // been refilled from sig_in; otherwise a pulse in flight at reset release
   // would look like a fresh rising edge.
   assign primed = prime_q[SS-1];

   // Input synchroniser, previous-value register for edge detect, fill tracker
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q  <= '0;
         prime_q <= '0;
         sp_q    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SS-2:0], sig_in};
         prime_q <= {prime_q[SS-2:0], 1'b1};
         sp_q    <= s;
      end
   end

   // One count step; a new pulse starts from zero so the rise cycle is high cycle 1
   always_comb begin
      base_p = (state_q == S_MEASURE) ? presc_q : '0;
      base_u = (state_q == S_MEASURE) ? us_q    : '0;
      wrap   = (base_p == PRESC_LAST);
      inc_p  = wrap ? '0 : base_p + PW'(1);
      inc_u  = wrap ? base_u + UW'(1) : base_u;
      hit    = wrap && ((base_u + UW'(1)) == US_MAX);
   end

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      us_d    = us_q;
      over_d  = over_q;
      case (state_q)
         S_IDLE: begin
            if (enable && primed) state_d = s ? S_WAIT_LOW : S_ARM;
         end
         S_WAIT_LOW: begin
            if (!s) state_d = S_ARM;
         end
         S_ARM: begin
            if (rise) begin
               presc_d = inc_p;
               us_d    = inc_u;
               over_d  = hit;
               state_d = hit ? S_OVER : S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (fall) begin
               state_d = S_DONE;
            end else if (s) begin
               presc_d = inc_p;
               us_d    = inc_u;
               over_d  = hit;
               if (hit) state_d = S_OVER;
            end
         end
         S_OVER: begin
            if (fall) state_d = S_DONE;
         end
         S_DONE: begin
            // A pulse separated by a single low cycle rises while we publish
            if (!enable) begin
               state_d = S_IDLE;
            end else if (rise) begin
               presc_d = inc_p;
               us_d    = inc_u;
               over_d  = hit;
               state_d = hit ? S_OVER : S_MEASURE;
            end else begin
               state_d = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!enable && (state_q != S_DONE)) state_d = S_IDLE;
   end

   // State and measurement counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         us_q    <= '0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         us_q    <= us_d;
         over_q  <= over_d;
      end
   end

   // Result register and one-cycle strobe, loaded while in DONE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         width_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            width_q <= us_q;
            ovf_q   <= over_q;
         end
      end
   end

   assign width_us = width_q;
   assign overflow = ovf_q;
   assign valid    = valid_q;
   assign busy     = (state_q == S_MEASURE) || (state_q == S_OVER);

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

   logic        CLK;
   logic        RST;
   logic        enable;
   logic        sig_in;
   logic [15:0] width_a;
   logic        valid_a, ovf_a, busy_a;
   logic [3:0]  width_b;
   logic        valid_b, ovf_b, busy_b;

   pulse_width_meter #(.CLOCK_SPEED_MHZ(12), .MAX_US(65535), .SYNC_STAGES(2)) dut_a (
      .CLK(CLK), .RST(RST), .enable(enable), .sig_in(sig_in),
      .width_us(width_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
   );

   pulse_width_meter #(.CLOCK_SPEED_MHZ(12), .MAX_US(15), .SYNC_STAGES(2)) dut_b (
      .CLK(CLK), .RST(RST), .enable(enable), .sig_in(sig_in),
      .width_us(width_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      int w;
      int o;
   } res_t;

   typedef struct {
      int hi;
      int lo;
      int wa;
      int oa;
      int wb;
      int ob;
   } vec_t;

   res_t qa[$];
   res_t qb[$];
   int   total = 0;
   int   bad   = 0;
   logic prev_va = 1'b0;
   logic prev_vb = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: floor(N / MHz), saturating at cap, overflow when the cap is reached
   function automatic res_t model(input int n, input int cap);
      res_t r;
      int   u;
      u   = n / 12;
      r.w = (u >= cap) ? cap : u;
      r.o = (u >= cap) ? 1 : 0;
      return r;
   endfunction

   task automatic expect_pulse(input int n);
      qa.push_back(model(n, 65535));
      qb.push_back(model(n, 15));
   endtask

   // One clock: observe at the falling edge, return just after the rising edge
   task automatic step();
      res_t r;
      @(negedge CLK);
      if (valid_a) begin
         chk("valid_a_repeat", prev_va, 0);
         if (qa.size() == 0) chk("valid_a_unexpected", valid_a, 0);
         else begin
            r = qa.pop_front();
            chk("width_a", width_a, r.w);
            chk("ovf_a", ovf_a, r.o);
         end
      end
      if (valid_b) begin
         chk("valid_b_repeat", prev_vb, 0);
         if (qb.size() == 0) chk("valid_b_unexpected", valid_b, 0);
         else begin
            r = qb.pop_front();
            chk("width_b", width_b, r.w);
            chk("ovf_b", ovf_b, r.o);
         end
      end
      prev_va = valid_a;
      prev_vb = valid_b;
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse(input int hi, input int lo);
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) step();
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{120, 20, 10, 0, 10, 0};
      vecs[1] = '{131, 11, 10, 0, 10, 0};
      vecs[2] = '{11,  20, 0,  0, 0,  0};
      vecs[3] = '{300, 20, 25, 0, 15, 1};
      vecs[4] = '{24,  20, 2,  0, 2,  0};
      vecs[5] = '{179, 6,  14, 0, 14, 0};
      vecs[6] = '{180, 6,  15, 0, 15, 1};
      vecs[7] = '{12,  1,  1,  0, 1,  0};
      vecs[8] = '{1,   9,  0,  0, 0,  0};

      RST    = 1'b1;
      enable = 1'b0;
      sig_in = 1'b0;
      repeat (3) step();
      chk("rst_width_a", width_a, 0);
      chk("rst_valid_a", valid_a, 0);
      chk("rst_ovf_a",   ovf_a,   0);
      chk("rst_busy_a",  busy_a,  0);
      chk("rst_width_b", width_b, 0);
      chk("rst_busy_b",  busy_b,  0);
      RST    = 1'b0;
      enable = 1'b1;
      repeat (5) step();

      // Latency: valid appears on the third edge after the first low sample
      expect_pulse(120);
      sig_in = 1'b1;
      repeat (60) step();
      chk("busy_mid_a", busy_a, 1);
      repeat (60) step();
      sig_in = 1'b0;
      repeat (3) step();
      chk("latency_early", valid_a, 0);
      step();
      chk("latency_on_time", valid_a, 1);
      repeat (10) step();
      chk("busy_after_a", busy_a, 0);
      drain();

      // Table of pulse widths, both saturation limits checked together
      for (int i = 0; i < 9; i++) begin
         qa.push_back('{vecs[i].wa, vecs[i].oa});
         qb.push_back('{vecs[i].wb, vecs[i].ob});
         if (vecs[i].hi == 300) begin
            sig_in = 1'b1;
            repeat (250) step();
            chk("busy_over_b", busy_b, 1);
            chk("busy_long_a", busy_a, 1);
            repeat (50) step();
            sig_in = 1'b0;
            repeat (vecs[i].lo) step();
         end else begin
            pulse(vecs[i].hi, vecs[i].lo);
         end
      end
      drain();

      // Enable raised while sig_in already high: that pulse is skipped
      enable = 1'b0;
      repeat (3) step();
      sig_in = 1'b1;
      repeat (5) step();
      enable = 1'b1;
      repeat (45) step();
      sig_in = 1'b0;
      repeat (20) step();
      expect_pulse(60);
      pulse(60, 20);
      drain();
      chk("late_en_width_a", width_a, 5);

      // Enable dropped mid-pulse: no result, busy falls one clock later
      sig_in = 1'b1;
      repeat (40) step();
      chk("drop_busy_before", busy_a, 1);
      enable = 1'b0;
      step();
      chk("drop_busy_after_a", busy_a, 0);
      chk("drop_busy_after_b", busy_b, 0);
      repeat (79) step();
      sig_in = 1'b0;
      repeat (20) step();
      chk("drop_keep_width_a", width_a, 5);
      chk("drop_keep_width_b", width_b, 5);
      enable = 1'b1;
      repeat (4) step();

      // Asynchronous reset in the middle of a pulse
      sig_in = 1'b1;
      repeat (30) step();
      #2 RST = 1'b1;
      #1;
      chk("arst_width_a", width_a, 0);
      chk("arst_busy_a",  busy_a,  0);
      chk("arst_valid_a", valid_a, 0);
      chk("arst_ovf_b",   ovf_b,   0);
      repeat (3) step();
      RST = 1'b0;
      repeat (50) step();
      sig_in = 1'b0;
      repeat (20) step();
      chk("arst_no_result", width_a, 0);
      expect_pulse(36);
      pulse(36, 20);
      drain();

      // Random widths and gaps against the reference model
      for (int i = 0; i < 40; i++) begin
         int hi;
         int lo;
         hi = $urandom_range(1, 250);
         lo = $urandom_range(1, 20);
         expect_pulse(hi);
         pulse(hi, lo);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
